// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: coin codes, coin values in nickels,
// and the payout FSM state encoding.
package vend_pkg;

    localparam logic [2:0] NO_COIN    = 3'd0;
    localparam logic [2:0] NICKEL     = 3'd1;
    localparam logic [2:0] DIME       = 3'd2;
    localparam logic [2:0] QUARTER    = 3'd3;
    localparam logic [2:0] HALFDOLLAR = 3'd4;
    localparam logic [2:0] DOLLAR     = 3'd5;

    // Denomination index i (0 = nickel .. 4 = dollar) matches the empty[] bit.
    localparam int NUM_DENOM = 5;

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        ISSUE,
        FINISH
    } disp_state_e;

    function automatic logic [4:0] coin_value(input logic [2:0] code);
        case (code)
            NICKEL:     return 5'd1;
            DIME:       return 5'd2;
            QUARTER:    return 5'd5;
            HALFDOLLAR: return 5'd10;
            DOLLAR:     return 5'd20;
            default:    return 5'd0;
        endcase
    endfunction

    // Codes run nickel..dollar in the same order as the denomination index.
    function automatic logic [2:0] denom_code(input int idx);
        return 3'(idx + 1);
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Handshake bundle between the vending machine / coin hopper (master)
// and the change dispenser (slave).
interface change_dispenser_if #(
    parameter int AW = 6
);
    logic          start;
    logic [AW-1:0] amount;
    logic [4:0]    empty;
    logic          ack;
    logic [2:0]    coin;
    logic          coin_valid;
    logic          busy;
    logic          done;
    logic          short;
    logic          fault;
    logic [AW-1:0] remaining;

    modport master (
        output start, amount, empty, ack,
        input  coin, coin_valid, busy, done, short, fault, remaining
    );

    modport slave (
        input  start, amount, empty, ack,
        output coin, coin_valid, busy, done, short, fault, remaining
    );
endinterface

// File: rtl/change_dispenser_coin_select.sv
// Combinational greedy picker: largest non-empty denomination whose value
// fits in the remaining amount.
module coin_select
    import vend_pkg::*;
#(
    parameter int AW = 6
) (
    input  logic [AW-1:0]        remaining,
    input  logic [NUM_DENOM-1:0] empty,
    output logic [2:0]           code,
    output logic                 none
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs (no latch).
        code = NO_COIN;
        none = 1'b1;
        // Ascending scan: the last qualifying denomination is the largest.
        for (int i = 0; i < NUM_DENOM; i++) begin
            if (!empty[i] && (32'(coin_value(denom_code(i))) <= 32'(remaining))) begin
                code = denom_code(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Payout engine: pays a change amount one coin at a time through the hopper
// handshake, reporting done, short and ack-timeout fault.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int AW          = 6,
    parameter int ACK_TIMEOUT = 1023
) (
    input logic                clock,
    input logic                reset,
    change_dispenser_if.slave  bus
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    disp_state_e   state_q, state_d;
    logic [2:0]    coin_q, coin_d;
    logic          coin_valid_q, coin_valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          short_q, short_d;
    logic          fault_q, fault_d;
    logic [AW-1:0] remaining_q, remaining_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [2:0]    sel_code;
    logic          sel_none;

    coin_select #(.AW(AW)) u_coin_select (
        .remaining (remaining_q),
        .empty     (bus.empty),
        .code      (sel_code),
        .none      (sel_none)
    );

    always_comb begin
        state_d      = state_q;
        coin_d       = coin_q;
        coin_valid_d = coin_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        short_d      = short_q;
        fault_d      = fault_q;
        remaining_d  = remaining_q;
        cnt_d        = cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    remaining_d = bus.amount;
                    short_d     = 1'b0;
                    fault_d     = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = SELECT;
                end
            end
            SELECT: begin
                if (remaining_q == '0 || sel_none) begin
                    short_d = (remaining_q != '0);
                    coin_d  = NO_COIN;
                    done_d  = 1'b1;
                    state_d = FINISH;
                end else begin
                    coin_d       = sel_code;
                    coin_valid_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.ack) begin
                    // Picker guarantees value <= remaining, so no underflow.
                    remaining_d  = remaining_q - AW'(coin_value(coin_q));
                    coin_valid_d = 1'b0;
                    cnt_d        = '0;
                    state_d      = SELECT;
                end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                    fault_d      = 1'b1;
                    coin_valid_d = 1'b0;
                    coin_d       = NO_COIN;
                    cnt_d        = '0;
                    done_d       = 1'b1;
                    state_d      = FINISH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FINISH: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            coin_q       <= NO_COIN;
            coin_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            short_q      <= 1'b0;
            fault_q      <= 1'b0;
            remaining_q  <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            coin_q       <= coin_d;
            coin_valid_q <= coin_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            short_q      <= short_d;
            fault_q      <= fault_d;
            remaining_q  <= remaining_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.coin       = coin_q;
    assign bus.coin_valid = coin_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.short      = short_q;
    assign bus.fault      = fault_q;
    assign bus.remaining  = remaining_q;

endmodule
